// File: rtl/gf163_pkg.sv
// Shared constants, state encoding and digit extraction for the GF(2^163) digit-serial multiplier.
package gf163_pkg;

    localparam int unsigned M              = 163;
    localparam int unsigned DIGIT_W        = 32;
    localparam int unsigned NUM_DIGITS     = 6;
    localparam int unsigned TOP_DIGIT_BITS = 3;

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } state_e;

    // Digit 5 carries only the three top field bits; the rest is forced to zero.
    function automatic logic [DIGIT_W-1:0] get_digit(input logic [M-1:0] b, input logic [2:0] k);
        logic [DIGIT_W-1:0] d;
        d = '0;
        unique case (k)
            3'd0:    d = b[31:0];
            3'd1:    d = b[63:32];
            3'd2:    d = b[95:64];
            3'd3:    d = b[127:96];
            3'd4:    d = b[159:128];
            3'd5:    d = {{(DIGIT_W-TOP_DIGIT_BITS){1'b0}}, b[M-1 -: TOP_DIGIT_BITS]};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/gf163_digit_feeder.sv
// Input stage of the GF(2^163) systolic multiplier: holds A parallel and streams B as
// six 32-bit digits, top digit first, with first/last framing and a stallable handshake.
module gf163_digit_feeder
    import gf163_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [M-1:0]       in_a,
    input  logic [M-1:0]       in_b,
    output logic [M-1:0]       a_out,
    output logic               dig_valid,
    input  logic               dig_ready,
    output logic [DIGIT_W-1:0] dig_out,
    output logic               dig_first,
    output logic               dig_last,
    output logic               busy
);

    localparam logic [2:0] TopIdx = 3'(NUM_DIGITS - 1);

    state_e             state_q;
    logic [2:0]         cnt_q;
    logic [M-1:0]       b_q;
    logic [M-1:0]       a_q;
    logic [DIGIT_W-1:0] dig_q;
    logic               valid_q;
    logic               first_q;
    logic               last_q;

    logic xfer;
    logic accept;

    assign xfer     = valid_q & dig_ready;
    // Accepting on the last transfer lets a new pair follow without a bubble.
    assign in_ready = ~abort & ((state_q == IDLE) | (xfer & last_q));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            a_q     <= '0;
            dig_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (abort) begin
            // Datapath registers keep their contents; only framing is dropped.
            state_q <= IDLE;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= STREAM;
            a_q     <= in_a;
            b_q     <= in_b;
            cnt_q   <= TopIdx;
            dig_q   <= get_digit(in_b, TopIdx);
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else if ((state_q == STREAM) && xfer) begin
            if (cnt_q == 3'd0) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_q - 3'd1;
                dig_q   <= get_digit(b_q, cnt_q - 3'd1);
                first_q <= 1'b0;
                last_q  <= (cnt_q == 3'd1);
            end
        end
    end

    assign a_out     = a_q;
    assign dig_out   = dig_q;
    assign dig_valid = valid_q;
    assign dig_first = first_q;
    assign dig_last  = last_q;
    assign busy      = (state_q == STREAM);

endmodule

// File: tb/tb_gf163_digit_feeder.sv
// Directed, table-driven bench for gf163_digit_feeder plus hand-written reset sequences.
module tb_gf163_digit_feeder;

    logic         clk;
    logic         rstn;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [162:0] in_a;
    logic [162:0] in_b;
    logic [162:0] a_out;
    logic         dig_valid;
    logic         dig_ready;
    logic [31:0]  dig_out;
    logic         dig_first;
    logic         dig_last;
    logic         busy;

    gf163_digit_feeder dut (
        .clk       (clk),
        .rstn      (rstn),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .a_out     (a_out),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .dig_out   (dig_out),
        .dig_first (dig_first),
        .dig_last  (dig_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         vld;
        logic [162:0] a;
        logic [162:0] b;
        logic         rdy;
        logic         abt;
        logic         e_ir;
        logic         e_dv;
        logic [31:0]  e_do;
        logic         e_f;
        logic         e_l;
        logic         e_busy;
        logic [162:0] e_a;
    } vec_t;

    localparam logic [162:0] B1   = {3'b101, 32'h11111111, 32'h22222222, 32'h33333333,
                                     32'h44444444, 32'h55555555};
    localparam logic [162:0] ONES = {163{1'b1}};
    localparam logic [162:0] A1   = {3'b011, {5{32'hA1A1_0001}}};
    localparam logic [162:0] A2   = {3'b110, {5{32'hA2A2_0002}}};
    localparam logic [162:0] A3   = {3'b001, {5{32'hA3A3_0003}}};
    localparam logic [162:0] A4   = {3'b100, {5{32'hA4A4_0004}}};
    localparam logic [162:0] A5   = {3'b010, {5{32'hA5A5_0005}}};

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input logic vld, input logic [162:0] a, input logic [162:0] b,
                       input logic rdy, input logic abt, input logic e_ir, input logic e_dv,
                       input logic [31:0] e_do, input logic e_f, input logic e_l,
                       input logic e_busy, input logic [162:0] e_a);
        vec_t v;
        v.vld = vld; v.a = a; v.b = b; v.rdy = rdy; v.abt = abt;
        v.e_ir = e_ir; v.e_dv = e_dv; v.e_do = e_do; v.e_f = e_f; v.e_l = e_l;
        v.e_busy = e_busy; v.e_a = e_a;
        vecs.push_back(v);
    endtask

    // Stream row: no new operand, downstream ready, expect a valid digit.
    task automatic dig(input logic [31:0] d, input logic f, input logic l, input logic [162:0] ea);
        add(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1, d, f, l, 1'b1, ea);
    endtask

    // Inputs are driven 1 time unit after a rising edge; in_ready is checked 1 unit
    // later and registered outputs 1 unit after the following rising edge.
    task automatic apply(input vec_t v, input int idx);
        logic ok;
        in_valid  = v.vld;
        in_a      = v.a;
        in_b      = v.b;
        dig_ready = v.rdy;
        abort     = v.abt;
        #1;
        n_vec++;
        if (in_ready !== v.e_ir) begin
            n_bad++;
            $display("FAIL vec%0d in_ready: got %b want %b", idx, in_ready, v.e_ir);
        end
        @(posedge clk);
        #1;
        ok = (dig_valid === v.e_dv) && (busy === v.e_busy) && (a_out === v.e_a);
        if (v.e_dv)
            ok = ok && (dig_out === v.e_do) && (dig_first === v.e_f) && (dig_last === v.e_l);
        else
            ok = ok && (dig_first === 1'b0) && (dig_last === 1'b0);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL vec%0d outputs: got dv=%b do=%h f=%b l=%b busy=%b a=%h want dv=%b do=%h f=%b l=%b busy=%b a=%h",
                     idx, dig_valid, dig_out, dig_first, dig_last, busy, a_out,
                     v.e_dv, v.e_do, v.e_f, v.e_l, v.e_busy, v.e_a);
        end
    endtask

    task automatic check1(input string name, input logic [162:0] got, input logic [162:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn = 1'b0; abort = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; dig_ready = 1'b0;

        // Single stream, full throughput
        add(1, A1, B1, 1, 0, 1, 1, 32'h00000005, 1, 0, 1, A1);
        dig(32'h11111111, 0, 0, A1);
        dig(32'h22222222, 0, 0, A1);
        dig(32'h33333333, 0, 0, A1);
        dig(32'h44444444, 0, 0, A1);
        dig(32'h55555555, 0, 1, A1);
        add(0, '0, '0, 1, 0, 1, 0, '0, 0, 0, 0, A1);
        add(0, '0, '0, 1, 0, 1, 0, '0, 0, 0, 0, A1);
        // Stall for three cycles on 22222222
        add(1, A2, B1, 1, 0, 1, 1, 32'h00000005, 1, 0, 1, A2);
        dig(32'h11111111, 0, 0, A2);
        dig(32'h22222222, 0, 0, A2);
        for (int i = 0; i < 3; i++)
            add(1, A3, ONES, 0, 0, 0, 1, 32'h22222222, 0, 0, 1, A2);
        dig(32'h33333333, 0, 0, A2);
        dig(32'h44444444, 0, 0, A2);
        dig(32'h55555555, 0, 1, A2);
        // Back-to-back accept on the last transfer; all-ones B checks top-digit masking
        add(1, A3, ONES, 1, 0, 1, 1, 32'h00000007, 1, 0, 1, A3);
        for (int i = 0; i < 4; i++)
            dig(32'hFFFFFFFF, 0, 0, A3);
        dig(32'hFFFFFFFF, 0, 1, A3);
        add(0, '0, '0, 1, 0, 1, 0, '0, 0, 0, 0, A3);
        // Abort at cnt==3 with a simultaneous in_valid
        add(1, A4, B1, 1, 0, 1, 1, 32'h00000005, 1, 0, 1, A4);
        dig(32'h11111111, 0, 0, A4);
        dig(32'h22222222, 0, 0, A4);
        add(1, A5, ONES, 1, 1, 0, 0, '0, 0, 0, 0, A4);
        add(0, '0, '0, 1, 0, 1, 0, '0, 0, 0, 0, A4);
        add(1, A5, B1, 1, 1, 0, 0, '0, 0, 0, 0, A4);
        add(1, A5, B1, 1, 0, 1, 1, 32'h00000005, 1, 0, 1, A5);
        dig(32'h11111111, 0, 0, A5);
        dig(32'h22222222, 0, 0, A5);
        dig(32'h33333333, 0, 0, A5);
        dig(32'h44444444, 0, 0, A5);
        dig(32'h55555555, 0, 1, A5);
        add(0, '0, '0, 1, 0, 1, 0, '0, 0, 0, 0, A5);

        // Reset state
        #2;
        check1("reset_dig_valid", 163'(dig_valid), 163'd0);
        check1("reset_dig_out", 163'(dig_out), 163'd0);
        check1("reset_a_out", a_out, '0);
        check1("reset_flags_busy", 163'({dig_first, dig_last, busy}), 163'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // Asynchronous reset while digit 4 is on the output
        in_valid = 1'b1; in_a = A1; in_b = B1; dig_ready = 1'b1; abort = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check1("pre_reset_digit4", 163'(dig_out), 163'h11111111);
        #2;
        rstn = 1'b0;
        #1;
        check1("midrst_dig_valid", 163'(dig_valid), 163'd0);
        check1("midrst_dig_out", 163'(dig_out), 163'd0);
        check1("midrst_a_out", a_out, '0);
        check1("midrst_busy", 163'(busy), 163'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check1("postrst_in_ready", 163'(in_ready), 163'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check1("postrst_no_digits", 163'({dig_valid, busy}), 163'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gf163_digit_feeder.md
Name: gf163_digit_feeder

Overview:
- Input stage of the 32-bit-digit GF(2^163) systolic multiplier.
- Accepts a 163-bit operand pair (A, B) through a valid/ready handshake.
- Holds A parallel and streams B as six 32-bit digits, most significant digit first, into the digit register chain with a stallable valid/ready interface.
- Frames each operand stream with first/last flags so downstream stages know where a product starts and ends.

Parameters:
M, 163, field degree (operand width)
DIGIT_W, 32, digit width
NUM_DIGITS, 6, ceil(M/DIGIT_W); index 5 is the top digit, 0 is the bottom digit

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
abort  input  1  synchronous flush of the current stream
in_valid  input  1  operand pair valid
in_ready  output  1  feeder can accept an operand pair
in_a  input  163  operand A
in_b  input  163  operand B (digit-serialised)
a_out  output  163  registered A, stable for the whole stream
dig_valid  output  1  dig_out valid
dig_ready  input  1  downstream accepts digit
dig_out  output  32  current B digit
dig_first  output  1  dig_out is digit 5 of the stream
dig_last  output  1  dig_out is digit 0 of the stream
busy  output  1  state is STREAM

Behaviour:
- Reset: rstn is asynchronous and active-low; clk is the clock. While rstn is low, state=IDLE, cnt=0, b_reg=0, a_out=0, dig_out=0, dig_valid=0, dig_first=0, dig_last=0, busy=0. in_ready is don't-care while rstn is low and is 1 from the first cycle after deassertion.
- Digit mapping:
  - digit k = b_reg[32k+31:32k] for k=0..4.
  - digit 5 = {29'b0, b_reg[162:160]}, i.e. zero-extended.
  - Digits are emitted in order 5,4,3,2,1,0.
- State machine: IDLE, STREAM. cnt is a 3-bit register holding the index of the digit currently on dig_out.
- in_ready (combinational) = ~abort & (state==IDLE | (dig_valid & dig_ready & dig_last)).
- accept = in_valid & in_ready. A handshake on accept captures in_a into a_out and in_b into b_reg.
- IDLE:
  - on accept -> STREAM.
  - Next cycle: dig_valid=1, dig_out=digit 5, dig_first=1, cnt=5.
  - Zero-latency path from in to dig_out is not allowed; latency from accept to first dig_valid is 1 cycle.
- STREAM:
  - A digit transfers when dig_valid & dig_ready.
  - On transfer with cnt>0: cnt decrements and dig_out/dig_first/dig_last update to the next digit on the following edge.
  - Stall: while dig_ready=0, dig_out, dig_first, dig_last, cnt, a_out and b_reg hold exactly.
  - dig_last=1 exactly when cnt==0. dig_first=1 exactly when cnt==5.
- Last digit transfer (cnt==0):
  - If accept occurs in the same cycle (back-to-back), load the new pair, stay in STREAM and present digit 5 of the new B next cycle. There is no bubble.
  - Otherwise -> IDLE with dig_valid=0, dig_first=0, dig_last=0.
- abort:
  - Has priority over all other events, including a simultaneous accept (which is suppressed because in_ready=0).
  - Next state IDLE, dig_valid=0, flags=0.
  - a_out, b_reg and dig_out retain their values.
  - abort in IDLE has no effect.
- Reset mid-stream: immediate return to reset values. The partial stream is discarded with no further digits.
- Width rule: in_b bits never leak into digit 5 bits [31:3]; they are always 0.
- Digit throughput: one digit per cycle under continuous dig_ready. A full operand pair takes 6 cycles; a sustained rate of one pair per 6 cycles is required.

Decomposition:
- Shared package gf163_pkg:
  - constants M=163, DIGIT_W=32, NUM_DIGITS=6, TOP_DIGIT_BITS=3.
  - state enum {IDLE, STREAM}.
  - function get_digit(b, k) returning the zero-extended 32-bit digit.
- No sub-module needed: the datapath is b_reg, a_out, one 6:1 digit mux and the counter/FSM in one module.

Test Plan:
1. Single stream, dig_ready=1. in_b = {3'b101, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555}, accepted at cycle t.
   -> Cycles t+1..t+6: dig_out = 00000005, 11111111, 22222222, 33333333, 44444444, 55555555.
   -> dig_first only at t+1, dig_last only at t+6, dig_valid=0 at t+7, a_out = in_a from t+1.
2. Stall. Same B, dig_ready=0 for 3 cycles while 22222222 is presented.
   -> dig_out=22222222 held with dig_valid=1 for 4 cycles.
   -> Stream completes with 6 total transfers, in_ready=0 throughout.
3. Back-to-back. Second pair B2 (all-ones 163 bits) with in_valid held high.
   -> Accepted in the cycle 55555555 transfers.
   -> Next cycle dig_out=00000007, dig_first=1, no bubble.
   -> Then FFFFFFFF x5.
4. Abort. Abort asserted while cnt==3, with in_valid=1 in the same cycle.
   -> Next cycle dig_valid=0, busy=0, no accept.
   -> A following accept restarts at digit 5.
5. Reset mid-stream. rstn pulled low asynchronously between edges during digit 4.
   -> dig_valid, dig_out and a_out read 0 immediately.
   -> After release, in_ready=1 and no digits appear until a new accept.
6. Top-digit masking. in_b = all ones.
   -> First digit equals 32'h00000007 exactly.
